// File: rtl/bytecode_fetch.sv
// bytecode_fetch: walks a synchronous bytecode ROM, assembling opcode plus 0-2 operand bytes
// into one instruction handed to the translator over a valid/ready handshake.
module bytecode_fetch #(
    parameter int         ADDR_WIDTH = 10,
    parameter int         START_ADDR = 0,
    parameter logic [7:0] RETURN_OP  = 8'hB1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_data,
    output logic                  bc_valid,
    input  logic                  bc_ready,
    output logic [7:0]            bc_opcode,
    output logic [7:0]            bc_operand1,
    output logic [7:0]            bc_operand2,
    output logic [1:0]            bc_num_operands,
    output logic [ADDR_WIDTH-1:0] bc_pc,
    output logic                  done
);
    typedef enum logic [2:0] {S_REQ, S_OP, S_OPND1, S_OPND2, S_OUT, S_HALT} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] bc_pc_q;
    logic [7:0]            opcode_q;
    logic [7:0]            operand1_q;
    logic [7:0]            operand2_q;
    logic [1:0]            n_q;
    logic [1:0]            n_d;
    logic                  valid_q;
    logic                  done_q;

    function automatic logic [1:0] opnd_count(input logic [7:0] op);
        return (op == 8'h10 || op == 8'h15 || op == 8'h36) ? 2'd1 :
               (op == 8'h11 || op == 8'h84 || op == 8'hA7 ||
                (op >= 8'h99 && op <= 8'hA4)) ? 2'd2 : 2'd0;
    endfunction

    assign n_d             = opnd_count(mem_data);
    assign mem_addr        = pc_q;
    assign bc_valid        = valid_q;
    assign bc_opcode       = opcode_q;
    assign bc_operand1     = operand1_q;
    assign bc_operand2     = operand2_q;
    assign bc_num_operands = n_q;
    assign bc_pc           = bc_pc_q;
    assign done            = done_q;

    // pc always points one past the byte whose data arrives next, so the opcode sits at pc-1
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_REQ;
            pc_q       <= ADDR_WIDTH'(START_ADDR);
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            opcode_q   <= '0;
            operand1_q <= '0;
            operand2_q <= '0;
            n_q        <= '0;
            bc_pc_q    <= '0;
        end else begin
            case (state_q)
                S_REQ: begin
                    pc_q    <= pc_q + ADDR_WIDTH'(1);
                    state_q <= S_OP;
                end
                S_OP: begin
                    opcode_q   <= mem_data;
                    bc_pc_q    <= pc_q - ADDR_WIDTH'(1);
                    n_q        <= n_d;
                    operand1_q <= '0;
                    operand2_q <= '0;
                    if (n_d != 2'd0) begin
                        pc_q    <= pc_q + ADDR_WIDTH'(1);
                        state_q <= S_OPND1;
                    end else begin
                        valid_q <= 1'b1;
                        state_q <= S_OUT;
                    end
                end
                S_OPND1: begin
                    operand1_q <= mem_data;
                    if (n_q == 2'd2) begin
                        pc_q    <= pc_q + ADDR_WIDTH'(1);
                        state_q <= S_OPND2;
                    end else begin
                        valid_q <= 1'b1;
                        state_q <= S_OUT;
                    end
                end
                S_OPND2: begin
                    operand2_q <= mem_data;
                    valid_q    <= 1'b1;
                    state_q    <= S_OUT;
                end
                S_OUT: begin
                    if (bc_ready) begin
                        valid_q <= 1'b0;
                        done_q  <= (opcode_q == RETURN_OP);
                        state_q <= (opcode_q == RETURN_OP) ? S_HALT : S_REQ;
                    end
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_bytecode_fetch.sv
// tb_bytecode_fetch: opcode table vectors, directed handshake/wrap/reset sequences and
// randomized programs checked against a byte-walking reference model.
module tb_bytecode_fetch;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] mem_addr, bc_pc, mem_addr_w, bc_pc_w;
    logic [7:0] mem_data, bc_opcode, bc_operand1, bc_operand2;
    logic [7:0] mem_data_w, bc_opcode_w, bc_operand1_w, bc_operand2_w;
    logic [1:0] bc_num_operands, bc_num_operands_w;
    logic       bc_valid, bc_ready = 1'b1, done;
    logic       bc_valid_w, bc_ready_w = 1'b0, done_w;
    logic [7:0] rom [0:1023];
    int         checks = 0;
    int         failures = 0;

    bytecode_fetch dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_data(mem_data),
        .bc_valid(bc_valid), .bc_ready(bc_ready), .bc_opcode(bc_opcode),
        .bc_operand1(bc_operand1), .bc_operand2(bc_operand2),
        .bc_num_operands(bc_num_operands), .bc_pc(bc_pc), .done(done)
    );

    bytecode_fetch #(.START_ADDR(1022)) dut_w (
        .clk(clk), .reset(reset), .mem_addr(mem_addr_w), .mem_data(mem_data_w),
        .bc_valid(bc_valid_w), .bc_ready(bc_ready_w), .bc_opcode(bc_opcode_w),
        .bc_operand1(bc_operand1_w), .bc_operand2(bc_operand2_w),
        .bc_num_operands(bc_num_operands_w), .bc_pc(bc_pc_w), .done(done_w)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_data   <= rom[mem_addr];
        mem_data_w <= rom[mem_addr_w];
    end

    typedef struct {
        logic [7:0] op;
        logic [1:0] n;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rec(input logic [7:0] op, input logic [7:0] o1,
                                        input logic [7:0] o2, input logic [1:0] n,
                                        input logic [9:0] pc);
        return {28'b0, op, o1, o2, n, pc};
    endfunction

    function automatic logic [63:0] cur();
        return rec(bc_opcode, bc_operand1, bc_operand2, bc_num_operands, bc_pc);
    endfunction

    function automatic logic [1:0] spec_n(input logic [7:0] op);
        if (op inside {8'h10, 8'h15, 8'h36}) return 2'd1;
        if (op inside {8'h11, 8'h84, 8'hA7, [8'h99:8'hA4]}) return 2'd2;
        return 2'd0;
    endfunction

    // reference: decode the instruction whose opcode is at byte a, return the following address
    task automatic model_at(input logic [9:0] a, output logic [63:0] r, output logic [9:0] nxt);
        logic [9:0] a1, a2;
        logic [1:0] n;
        a1  = a + 10'd1;
        a2  = a + 10'd2;
        n   = spec_n(rom[a]);
        r   = rec(rom[a], (n >= 2'd1) ? rom[a1] : 8'h00, (n == 2'd2) ? rom[a2] : 8'h00, n, a);
        nxt = a + 10'd1 + 10'(n);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bc_valid) begin
                lat = i;
                return;
            end
        end
    endtask

    initial begin
        vec_t        tbl [14];
        int          lat;
        logic [63:0] q [$];
        logic [63:0] r;
        logic [9:0]  a;
        int          idx, cyc;
        logic        rn;

        tbl = '{'{8'h10, 2'd1}, '{8'h15, 2'd1}, '{8'h36, 2'd1}, '{8'h11, 2'd2},
                '{8'h84, 2'd2}, '{8'h99, 2'd2}, '{8'hA0, 2'd2}, '{8'hA4, 2'd2},
                '{8'hA7, 2'd2}, '{8'h98, 2'd0}, '{8'hA5, 2'd0}, '{8'h00, 2'd0},
                '{8'hFF, 2'd0}, '{8'h12, 2'd0}};
        clear_rom();

        do_reset();
        chk("reset_outputs", {cur(), 2'(bc_valid), 2'(done), 10'(mem_addr)}, 64'h0);
        chk("reset_start_w", 64'(mem_addr_w), 64'd1022);

        foreach (tbl[i]) begin
            clear_rom();
            rom[0] = tbl[i].op;
            rom[1] = 8'h5A;
            rom[2] = 8'hC3;
            bc_ready = 1'b1;
            do_reset();
            wait_valid(lat);
            chk($sformatf("tbl_lat_%02h", tbl[i].op), 64'(lat), 64'(2 + tbl[i].n));
            chk($sformatf("tbl_rec_%02h", tbl[i].op), cur(),
                rec(tbl[i].op, (tbl[i].n >= 1) ? 8'h5A : 8'h00,
                    (tbl[i].n == 2) ? 8'hC3 : 8'h00, tbl[i].n, 10'd0));
        end

        clear_rom();
        rom[0] = 8'h03; rom[1] = 8'h3B; rom[2] = 8'h1A; rom[3] = 8'hB1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wait_valid(lat);
            chk($sformatf("seq_lat_%0d", k), 64'(lat), (k == 0) ? 64'd2 : 64'd3);
            chk($sformatf("seq_rec_%0d", k), cur(), rec(rom[k], 8'h00, 8'h00, 2'd0, 10'(k)));
        end
        @(negedge clk);
        chk("seq_done", {62'b0, bc_valid, done}, 64'd1);

        clear_rom();
        rom[0] = 8'h10; rom[1] = 8'h7F; rom[2] = 8'h36; rom[3] = 8'h05;
        do_reset();
        wait_valid(lat);
        chk("op1_lat0", 64'(lat), 64'd3);
        chk("op1_rec0", cur(), rec(8'h10, 8'h7F, 8'h00, 2'd1, 10'd0));
        wait_valid(lat);
        chk("op1_lat1", 64'(lat), 64'd4);
        chk("op1_rec1", cur(), rec(8'h36, 8'h05, 8'h00, 2'd1, 10'd2));

        clear_rom();
        rom[0] = 8'h11; rom[1] = 8'h12; rom[2] = 8'h34;
        bc_ready = 1'b0;
        do_reset();
        wait_valid(lat);
        chk("stall_lat", 64'(lat), 64'd4);
        for (int k = 0; k < 5; k++) begin
            chk("stall_hold", {cur(), 2'(bc_valid), 10'(mem_addr)},
                {rec(8'h11, 8'h12, 8'h34, 2'd2, 10'd0), 2'd1, 10'd3});
            bc_ready = (k == 4);
            @(negedge clk);
        end
        chk("stall_xfer", 64'(bc_valid), 64'd0);
        wait_valid(lat);
        chk("stall_next_pc", 64'(bc_pc), 64'd3);

        clear_rom();
        rom[1022] = 8'h11; rom[1023] = 8'hAB; rom[0] = 8'hCD;
        bc_ready_w = 1'b0;
        do_reset();
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            if (bc_valid_w) lat = i;
        end
        chk("wrap_lat", 64'(lat), 64'd4);
        chk("wrap_rec", rec(bc_opcode_w, bc_operand1_w, bc_operand2_w, bc_num_operands_w, bc_pc_w),
            rec(8'h11, 8'hAB, 8'hCD, 2'd2, 10'd1022));
        chk("wrap_addr", 64'(mem_addr_w), 64'd1);
        bc_ready_w = 1'b1;
        @(negedge clk);
        bc_ready_w = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            if (bc_valid_w) lat = i;
        end
        chk("wrap_next_pc", 64'(bc_pc_w), 64'd1);

        clear_rom();
        rom[0] = 8'h84; rom[1] = 8'h05; rom[2] = 8'hFF;
        bc_ready = 1'b1;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre", 64'(bc_valid), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_reset", {cur(), 2'(bc_valid), 10'(mem_addr)}, 64'h0);
        reset = 1'b0;
        wait_valid(lat);
        chk("abort_lat", 64'(lat), 64'd4);
        chk("abort_rec", cur(), rec(8'h84, 8'h05, 8'hFF, 2'd2, 10'd0));

        clear_rom();
        rom[1] = 8'hB1;
        do_reset();
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        chk("halt_done", {62'b0, bc_valid, done}, 64'd1);
        for (int k = 0; k < 10; k++) begin
            bc_ready = ~bc_ready;
            @(negedge clk);
            chk("halt_frozen", {52'b0, bc_valid, done, mem_addr}, {52'b0, 2'b01, 10'd2});
        end
        bc_ready = 1'b1;
        do_reset();
        chk("halt_restart", {52'b0, 2'(done), mem_addr}, 64'd0);
        wait_valid(lat);
        chk("halt_restart_pc", 64'(bc_pc), 64'd0);

        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 1024; i++) begin
                rom[i] = 8'($urandom_range(0, 255));
                if (rom[i] == 8'hB1) rom[i] = 8'h00;
            end
            q.delete();
            a = 10'd0;
            for (int k = 0; k < 25; k++) begin
                model_at(a, r, a);
                q.push_back(r);
            end
            rom[a] = 8'hB1;
            model_at(a, r, a);
            q.push_back(r);
            do_reset();
            idx = 0;
            cyc = 0;
            while (idx < q.size() && cyc < 2000) begin
                @(negedge clk);
                cyc++;
                if (bc_valid) chk("rand_xfer", cur(), q[idx]);
                rn = 1'($urandom_range(0, 1));
                if (bc_valid && rn) idx++;
                bc_ready = rn;
            end
            chk("rand_progress", 64'(idx), 64'(q.size()));
            @(negedge clk);
            chk("rand_done", {62'b0, bc_valid, done}, 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bytecode_fetch.md
BYTECODE_FETCH -- requirements
Module: bytecode_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, bytecode byte-address width (1024-byte space).
REQ-002 Parameter START_ADDR, default 0, first opcode address after reset.
REQ-003 Parameter RETURN_OP, default 8'hB1, opcode that ends fetching.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mem_addr  output  ADDR_WIDTH  byte address to bytecode ROM.
REQ-007 mem_data  input  8  ROM data; valid the cycle after mem_addr is presented (synchronous ROM).
REQ-008 bc_valid  output  1  decoded instruction available.
REQ-009 bc_ready  input  1  translator accepts the instruction.
REQ-010 bc_opcode  output  8  Java opcode.
REQ-011 bc_operand1  output  8  first operand byte; 0 if absent.
REQ-012 bc_operand2  output  8  second operand byte; 0 if absent.
REQ-013 bc_num_operands  output  2  operand count (0..2).
REQ-014 bc_pc  output  ADDR_WIDTH  address of the opcode byte.
REQ-015 done  output  1  RETURN_OP accepted; fetching stopped.

Function
REQ-016 Internal pc register SHALL hold the next byte address; mem_addr SHALL equal pc combinationally.
REQ-017 FSM states SHALL be S_REQ, S_OP, S_OPND1, S_OPND2, S_OUT, S_HALT.
REQ-018 S_REQ: pc<=pc+1; next S_OP.
REQ-019 S_OP: latch bc_opcode<=mem_data, bc_pc<=pc-1, operand count n from table; if n>=1 then pc<=pc+1 and next S_OPND1, else next S_OUT.
REQ-020 Operand table SHALL be: 0x10 bipush, 0x15 iload, 0x36 istore -> 1; 0x11 sipush, 0x84 iinc, 0x99-0xA4 if*/if_icmp*, 0xA7 goto -> 2; all other opcodes -> 0.
REQ-021 S_OPND1: bc_operand1<=mem_data; if n==2 then pc<=pc+1 and next S_OPND2, else next S_OUT.
REQ-022 S_OPND2: bc_operand2<=mem_data; next S_OUT.
REQ-023 Unused operand fields SHALL be cleared to 0 in S_OP.
REQ-024 bc_valid SHALL be 1 only in S_OUT.
REQ-025 S_OUT with bc_ready=0: remain; all bc_* outputs SHALL hold stable.
REQ-026 S_OUT with bc_ready=1: transfer; next S_HALT if bc_opcode==RETURN_OP, else S_REQ.
REQ-027 S_HALT: done=1, bc_valid=0, pc frozen; remain until reset.
REQ-028 Latency from entering S_REQ to bc_valid=1 SHALL be 2/3/4 cycles for n=0/1/2; idle cycles between transfers SHALL be 2+n with bc_ready held high.
REQ-029 pc SHALL wrap from 2^ADDR_WIDTH-1 to 0 with no flag, including mid-instruction (operands then read from 0, 1).
REQ-030 bc_ready while bc_valid=0 SHALL be ignored.
REQ-031 Unknown opcodes SHALL pass through with n=0, no error.

Reset
REQ-032 reset=1 at a rising edge SHALL set state S_REQ, pc=START_ADDR, bc_valid=0, done=0, bc_opcode=0, bc_operand1=0, bc_operand2=0, bc_num_operands=0, bc_pc=0.
REQ-033 Reset SHALL take priority in every state, including S_OUT with bc_ready=1 and S_HALT; a pending instruction is discarded.

Verification
REQ-034 ROM 03 3B 1A B1, bc_ready=1 -> four transfers (03,n0,pc0),(3B,pc1),(1A,pc2),(B1,pc3); done=1 one cycle after last; bc_valid first high 2 cycles after reset release.
REQ-035 ROM 10 7F 36 05 -> (10,op1=7F,op2=00,n1,pc0) then (36,op1=05,n1,pc2); 3 cycles S_REQ->valid each.
REQ-036 ROM 11 12 34, bc_ready=0 for 5 cycles after valid -> outputs hold (11,12,34,n2,pc0) unchanged, mem_addr held at 3; transfer on first ready.
REQ-037 START_ADDR=1022, ROM[1022]=11, ROM[1023]=AB, ROM[0]=CD -> (11,AB,CD,n2,pc1022); next opcode fetched from address 1.
REQ-038 Reset asserted one cycle in S_OPND1 of a 0x84 fetch -> bc_valid stays 0, next fetch restarts at START_ADDR, operands 0 until new latch.
REQ-039 After done=1, toggle bc_ready for 10 cycles -> no bc_valid, pc constant; reset -> fetch restarts at START_ADDR.
